// File: rtl/hack_pkg.sv
// Shared constants, region type and address decoder for the Hack data-memory/IO stage.
package hack_pkg;

  localparam int HACK_SCR_BASE  = 16384;
  localparam int HACK_KBD_ADDR  = 24576;
  localparam int HACK_MEM_WORDS = 24576;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCR,
    REG_KBD,
    REG_NONE
  } region_t;

  // 0..16383 RAM, 16384..24575 screen, 24576 KBD, everything above unmapped
  function automatic region_t hack_decode(input logic [14:0] addr);
    if (addr[14] == 1'b0)        return REG_RAM;
    else if (addr[13] == 1'b0)   return REG_SCR;
    else if (addr[12:0] == '0)   return REG_KBD;
    else                         return REG_NONE;
  endfunction

endpackage

// File: rtl/hack_mem_map_scr_fifo.sv
// Synchronous FIFO carrying screen writes to the video stage; push is accepted
// when full only if a pop happens on the same edge.
module scr_fifo #(
  parameter int W = 29,
  parameter int D = 8
) (
  input  logic         clk50m,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW_F = $clog2(D);
  localparam logic [AW_F:0] FULL_CNT = (AW_F + 1)'(D);

  logic [AW_F:0] r_wptr;
  logic [AW_F:0] r_rptr;
  logic [W-1:0]  r_mem [0:D-1];
  logic [AW_F:0] w_count;
  logic          w_pop;
  logic          w_push;

  assign w_count = r_wptr - r_rptr;
  assign empty   = (w_count == '0);
  assign full    = (w_count == FULL_CNT);
  assign w_pop   = pop && !empty;
  assign w_push  = push && (!full || w_pop);

  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk50m) begin
    if (w_push) r_mem[r_wptr[AW_F-1:0]] <= din;
  end

  // Head is forced to zero when empty so a flushed FIFO presents a clean bus
  assign dout = empty ? '0 : r_mem[r_rptr[AW_F-1:0]];

endmodule

// File: rtl/hack_mem_map.sv
// Hack CPU data-memory/IO stage: RAM + screen mirror, KBD register, screen-write FIFO.
// Optional macro HACK_KBD_SYNC_EN adds a 2-stage synchronizer on kbd_code.
module hack_mem_map
  import hack_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 15,
  parameter int SAW    = 13,
  parameter int FIFO_D = 8
) (
  input  logic           clk50m,
  input  logic           rst,
  input  logic           en25m,
  input  logic [AW-1:0]  addressM,
  input  logic           writeM,
  input  logic [DW-1:0]  outM,
  output logic [DW-1:0]  inM,
  input  logic [DW-1:0]  kbd_code,
  output logic           scr_valid,
  input  logic           scr_ready,
  output logic [SAW-1:0] scr_addr,
  output logic [DW-1:0]  scr_data,
  output logic           scr_ovf
);

  logic [DW-1:0]     r_mem [0:HACK_MEM_WORDS-1];
  logic [DW-1:0]     r_inm;
  logic              r_ovf;
  region_t           w_region;
  logic              w_wr;
  logic              w_scr_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DW-1:0]     w_kbd;
  logic [SAW+DW-1:0] w_fifo_dout;

  assign w_region   = hack_decode(addressM);
  assign w_wr       = en25m && writeM;
  assign w_scr_push = w_wr && (w_region == REG_SCR);
  assign w_pop      = !w_empty && scr_ready;

`ifdef HACK_KBD_SYNC_EN
  logic [DW-1:0] r_kbd_s1;
  logic [DW-1:0] r_kbd_s2;

  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_kbd_s1 <= '0;
      r_kbd_s2 <= '0;
    end else begin
      r_kbd_s1 <= kbd_code;
      r_kbd_s2 <= r_kbd_s1;
    end
  end

  assign w_kbd = r_kbd_s2;
`else
  assign w_kbd = kbd_code;
`endif

  always_ff @(posedge clk50m) begin
    if (w_wr && (w_region == REG_RAM || w_region == REG_SCR)) r_mem[addressM] <= outM;
  end

  // The KBD register is the read register itself on KBD reads, giving one cycle key-to-inM
  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_inm <= '0;
    end else begin
      case (w_region)
        REG_RAM, REG_SCR: r_inm <= r_mem[addressM];
        REG_KBD:          r_inm <= w_kbd;
        default:          r_inm <= '0;
      endcase
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst)                                   r_ovf <= 1'b0;
    else if (w_scr_push && w_full && !w_pop)   r_ovf <= 1'b1;
  end

  // Screen base is bit 14, so the low SAW bits are the screen word address
  scr_fifo #(
    .W (SAW + DW),
    .D (FIFO_D)
  ) u_scr_fifo (
    .clk50m (clk50m),
    .rst    (rst),
    .push   (w_scr_push),
    .pop    (w_pop),
    .din    ({addressM[SAW-1:0], outM}),
    .full   (w_full),
    .empty  (w_empty),
    .dout   (w_fifo_dout)
  );

  assign inM       = r_inm;
  assign scr_valid = !w_empty;
  assign scr_addr  = w_fifo_dout[SAW+DW-1:DW];
  assign scr_data  = w_fifo_dout[DW-1:0];
  assign scr_ovf   = r_ovf;

endmodule
